pwm_burst_scheduler: RTL and testbench
======================================

// Module: pwm_burst_scheduler
// PURPOSE
// Shares one pulse-burst timing engine between three requesters and drives
// three PWM pins (pwm[2:0]). Each requester submits a burst: half-period and
// pulse count. Bursts run one at a time, with round-robin arbitration.
// Sits between the control logic (key/command decode) and the pwm output pins.
// An idle pin, or a pin whose burst has finished, is always held low.
// PARAMETERS
// CNT_W    16  width of the half-period counter and the pulse counter
// GAP_CYC  4   idle cycles forced between consecutive bursts (0 = none)
// PORTS
// sys_clk          in   1        system clock; all logic on rising edge
// sys_rst_n        in   1        asynchronous active-low reset
// req_valid        in   3        per-channel burst request
// req_ready        out  3        per-channel accept; one-hot or zero
// req_half_period  in   3*CNT_W  channel i uses slice [i*CNT_W +: CNT_W]
// req_pulses       in   3*CNT_W  full pulses per burst; same slicing
// abort            in   1        kill the running burst (synchronous)
// pwm              out  3        pulse outputs; registered
// done             out  3        1-cycle pulse when a channel's burst completes
// busy             out  1        high in LOAD/RUN/GAP
// active_ch        out  2        channel being served; 2'd3 when idle
// BEHAVIOUR
// - Reset (async, sys_rst_n=0): state=IDLE; pwm=0; done=0; busy=0;
//   active_ch=3; rr pointer=2 (so ch0 has first priority). Counters cleared.
// - States: IDLE -> LOAD -> RUN -> GAP -> IDLE. GAP is skipped if GAP_CYC=0.
// - IDLE arbitration: search req_valid starting at rr+1 mod 3.
//   req_ready[g] is combinational and asserted only in IDLE, for the winner g.
//   Handshake = req_valid[g] & req_ready[g]. It latches hp, n and ch=g.
//   rr<=g; next state LOAD.
// - req_ready is never asserted outside IDLE. Requesters hold valid and data
//   stable until accepted.
// - hp==0 is treated as hp=1.
// - n==0: LOAD asserts done[ch] for 1 cycle, no pulse is produced, then GAP.
// - LOAD (1 cycle): pwm[ch]<=1; phase counter<=hp-1; pulse counter<=n.
//   pwm[ch] rises exactly 1 cycle after the handshake edge.
// - RUN: pwm[ch] is high for hp cycles, then low for hp cycles (one pulse).
//   Pulse counter decrements at the end of each low phase.
//   If more pulses remain, pwm goes high again with no dead cycle.
//   After the last low phase: done[ch]=1 for 1 cycle; pwm stays 0; go to GAP.
//   Total burst = 2*hp*n cycles from first rise to the done cycle.
// - GAP: count GAP_CYC cycles with busy=1, then IDLE.
//   active_ch=3 from GAP onward.
// - abort in LOAD/RUN: pwm<=0 on the next edge; no done pulse; go to GAP.
//   abort in IDLE/GAP is ignored.
// - abort has priority over a pulse completion in the same cycle.
// - Only pwm[active_ch] may ever be 1. The others are held 0.
// - Counters are CNT_W bits and never wrap mid-burst.
//   Max burst = 2*(2^CNT_W-1)^2 cycles.
// - Reset mid-burst: pwm drops to 0 immediately (async); the burst is lost.
// TESTING
// 1 ch1 valid hp=3 n=2 -> ready[1] for 1 cycle; pwm[1] = 111000111000
//   starting 1 cycle after accept; done[1] on cycle 13; busy low after GAP.
// 2 ch0,1,2 valid together, hp=1 n=1 -> served in order 0,1,2, each
//   separated by 4 GAP cycles. Re-request ch0,ch2 -> order 0,2.
// 3 ch2 hp=0 n=1 -> same waveform as hp=1 (10); ch0 n=0 -> done[0] in the
//   LOAD cycle, pwm[0] stays 0.
// 4 ch0 hp=5 n=10, abort on cycle 23 -> pwm[0]=0 the next cycle, no done,
//   ch1 (pending) accepted after the GAP.
// 5 sys_rst_n low mid-RUN -> pwm=0 asynchronously; after release, all
//   outputs at reset values and ch0 wins the first arbitration.

Source files
------------

// File: rtl/pwm_burst_scheduler.sv
// Three-requester pulse-burst scheduler: one shared half-period/pulse-count engine,
// round-robin arbitration between bursts, one registered PWM pin per requester.
module pwm_burst_scheduler #(
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    input  logic [3*CNT_W-1:0]   req_half_period,
    input  logic [3*CNT_W-1:0]   req_pulses,
    input  logic                 abort,
    output logic [2:0]           pwm,
    output logic [2:0]           done,
    output logic                 busy,
    output logic [1:0]           active_ch
);
    localparam int NUM_CH = 3;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam state_t S_AFTER = (GAP_CYC > 0) ? S_GAP : S_IDLE;

    typedef struct packed {
        logic [1:0]       ch;
        logic [CNT_W-1:0] hpm1;
    } burst_t;

    state_t                        r_state;
    burst_t                        r_bst;
    logic [1:0]                    r_rr;
    logic [CNT_W-1:0]              r_pulse_cnt;
    logic [CNT_W-1:0]              r_phase_cnt;
    logic [GAP_W-1:0]              r_gap_cnt;
    logic [NUM_CH-1:0]             r_pwm;
    logic [NUM_CH-1:0]             r_done;

    logic [NUM_CH-1:0][CNT_W-1:0]  w_hp;
    logic [NUM_CH-1:0][CNT_W-1:0]  w_n;
    logic [1:0]                    w_pri0, w_pri1, w_pri2;
    logic [1:0]                    w_grant;
    logic                          w_grant_vld;
    logic                          w_hs;
    logic [CNT_W-1:0]              w_hp_sel;
    logic [CNT_W-1:0]              w_n_sel;
    logic [CNT_W-1:0]              w_hpm1;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_hp[g] = req_half_period[g*CNT_W +: CNT_W];
        assign w_n[g]  = req_pulses[g*CNT_W +: CNT_W];
    end

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Search order starts just after the last channel served.
    assign w_pri0 = next_ch(r_rr);
    assign w_pri1 = next_ch(w_pri0);
    assign w_pri2 = next_ch(w_pri1);

    always_comb begin
        w_grant_vld = 1'b1;
        w_grant     = w_pri0;
        if (req_valid[w_pri0])
            w_grant = w_pri0;
        else if (req_valid[w_pri1])
            w_grant = w_pri1;
        else if (req_valid[w_pri2])
            w_grant = w_pri2;
        else
            w_grant_vld = 1'b0;
    end

    assign req_ready = (r_state == S_IDLE && w_grant_vld) ? (3'b001 << w_grant) : 3'b000;
    assign w_hs      = |(req_valid & req_ready);
    assign w_hp_sel  = w_hp[w_grant];
    assign w_n_sel   = w_n[w_grant];
    // A zero half-period runs as one cycle per phase.
    assign w_hpm1    = (w_hp_sel == '0) ? '0 : w_hp_sel - CNT_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_bst       <= '0;
            r_rr        <= 2'd2;
            r_pulse_cnt <= '0;
            r_phase_cnt <= '0;
            r_gap_cnt   <= '0;
            r_pwm       <= '0;
            r_done      <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_bst.ch        <= w_grant;
                        r_bst.hpm1      <= w_hpm1;
                        r_pulse_cnt     <= w_n_sel;
                        r_rr            <= w_grant;
                        r_done[w_grant] <= (w_n_sel == '0);
                        r_state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort || r_pulse_cnt == '0) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_AFTER;
                    end else begin
                        r_pwm[r_bst.ch] <= 1'b1;
                        r_phase_cnt     <= r_bst.hpm1;
                        r_state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_pwm     <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_AFTER;
                    end else if (r_phase_cnt != '0) begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end else if (r_pwm[r_bst.ch]) begin
                        r_pwm[r_bst.ch] <= 1'b0;
                        r_phase_cnt     <= r_bst.hpm1;
                    end else begin
                        // End of a low phase closes one full pulse.
                        r_pulse_cnt <= r_pulse_cnt - CNT_W'(1);
                        if (r_pulse_cnt == CNT_W'(1)) begin
                            r_done[r_bst.ch] <= 1'b1;
                            r_gap_cnt        <= GAP_LOAD;
                            r_state          <= S_AFTER;
                        end else begin
                            r_pwm[r_bst.ch] <= 1'b1;
                            r_phase_cnt     <= r_bst.hpm1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pwm       = r_pwm;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign active_ch = (r_state == S_LOAD || r_state == S_RUN) ? r_bst.ch : 2'd3;

endmodule

// File: tb/tb_pwm_burst_scheduler.sv
// Bench for pwm_burst_scheduler: scenario tasks plus a randomized run, all
// checked against a burst-timeline model (offset since accept -> expected pins).
module tb_pwm_burst_scheduler;
    localparam int CNT_W = 16;
    localparam int GAP   = 4;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [2:0]         req_valid = '0;
    logic [3*CNT_W-1:0] req_half_period = '0;
    logic [3*CNT_W-1:0] req_pulses = '0;
    logic               abort = 1'b0;
    logic [2:0]         req_ready, pwm, done;
    logic               busy;
    logic [1:0]         active_ch;

    always #5 sys_clk = ~sys_clk;

    pwm_burst_scheduler #(.CNT_W(CNT_W), .GAP_CYC(GAP)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_half_period(req_half_period), .req_pulses(req_pulses),
        .abort(abort), .pwm(pwm), .done(done), .busy(busy), .active_ch(active_ch)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: a burst is a timeline indexed by j = edges since the accept edge.
    // j=0 load, 1..B pulse train, B+1 done, up to B+GAP gap, then idle.
    int m_eng, m_j, m_ch, m_hp, m_n, m_B, m_done_ok, m_rr;
    int hs_ch;
    logic [2:0] exp_ready, exp_pwm, exp_done, obs_ready, obs_valid;
    logic       exp_busy;
    logic [1:0] exp_active;

    function automatic int pick_winner();
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_rr + k) % 3;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int oh2int(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_outputs();
        exp_busy   = (m_eng != 0);
        exp_active = (m_eng != 0 && m_j <= m_B) ? 2'(m_ch) : 2'd3;
        exp_pwm    = (m_eng != 0 && m_n > 0 && m_j >= 1 && m_j <= m_B && ((m_j - 1) / m_hp) % 2 == 0)
                     ? 3'(1 << m_ch) : 3'b000;
        exp_done   = (m_eng != 0 && ((m_n == 0 && m_j == 0) || (m_n > 0 && m_done_ok != 0 && m_j == m_B + 1)))
                     ? 3'(1 << m_ch) : 3'b000;
    endtask

    task automatic model_reset();
        m_eng = 0; m_j = 0; m_ch = 0; m_hp = 1; m_n = 0; m_B = 0; m_done_ok = 0; m_rr = 2;
        exp_ready = 3'b000;
        model_outputs();
    endtask

    function automatic logic [11:0] obs_vec();
        return {obs_ready, pwm, done, busy, active_ch};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {exp_ready, exp_pwm, exp_done, exp_busy, exp_active};
    endfunction

    // Advance one clock: sample ready before the edge, step the model on the edge,
    // release an accepted requester afterwards. Returns 1 time unit after the edge.
    task automatic cycle();
        int w, hp_s, n_s;
        @(negedge sys_clk);
        w = (m_eng != 0) ? -1 : pick_winner();
        exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
        obs_ready = req_ready;
        obs_valid = req_valid;
        hp_s = 0; n_s = 0;
        if (w >= 0) begin
            hp_s = int'(req_half_period[w*CNT_W +: CNT_W]);
            n_s  = int'(req_pulses[w*CNT_W +: CNT_W]);
        end
        @(posedge sys_clk);
        hs_ch = -1;
        if (m_eng == 0) begin
            if (w >= 0) begin
                m_eng = 1; m_j = 0; m_ch = w; m_rr = w; hs_ch = w;
                m_hp = (hp_s == 0) ? 1 : hp_s;
                m_n  = n_s;
                m_B  = (m_n == 0) ? 0 : 2 * m_hp * m_n;
                m_done_ok = 1;
            end
        end else begin
            if (abort && m_j <= m_B) begin
                m_B = m_j;
                m_done_ok = 0;
            end
            m_j++;
            if (m_j > m_B + GAP) m_eng = 0;
        end
        cyc++;
        #1;
        if (hs_ch >= 0) req_valid[hs_ch] = 1'b0;
        model_outputs();
    endtask

    task automatic set_req(input int ch, input int hp, input int n);
        req_half_period[ch*CNT_W +: CNT_W] = CNT_W'(hp);
        req_pulses[ch*CNT_W +: CNT_W]      = CNT_W'(n);
        req_valid[ch] = 1'b1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        abort = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({req_ready, pwm, done, busy, active_ch} !== {3'b000, 3'b000, 3'b000, 1'b0, 2'd3}) begin
            miscompares++;
            $display("FAIL reset_state got %b want %b", {req_ready, pwm, done, busy, active_ch}, 12'b000000000011);
        end
        repeat (3) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d {rdy,pwm,done,busy,act} got %b want %b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_burst();
        logic [11:0] pat;
        do_reset();
        set_req(1, 3, 2);
        cycle();
        vectors++;
        if (obs_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL single_accept ready got %b want 010", obs_ready);
        end
        pat = '0;
        for (int i = 1; i <= 17; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i <= 12) pat = {pat[10:0], pwm[1]};
            if (i == 13) begin
                vectors++;
                if (done !== 3'b010) begin
                    miscompares++;
                    $display("FAIL single_done13 got %b want 010", done);
                end
            end
            if (i == 16 || i == 17) begin
                vectors++;
                if (busy !== (i == 16)) begin
                    miscompares++;
                    $display("FAIL single_busy_cyc%0d got %b want %b", i, busy, (i == 16));
                end
            end
        end
        vectors++;
        if (pat !== 12'b111000111000) begin
            miscompares++;
            $display("FAIL single_waveform got %b want 111000111000", pat);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        do_reset();
        set_req(0, 1, 1); set_req(1, 1, 1); set_req(2, 1, 1);
        for (int i = 0; i < 40; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rr_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
            if (|(obs_ready & obs_valid)) begin
                order.push_back(oh2int(obs_ready & obs_valid));
                when.push_back(i);
            end
        end
        vectors++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            miscompares++;
            $display("FAIL rr_order got %0d grants %p want 0,1,2", order.size(), order);
        end
        // accept-to-accept: 2*hp*n pulse cycles + load + 4 gap + 1 idle = 8
        vectors++;
        if (when.size() != 3 || when[1] - when[0] != 8 || when[2] - when[1] != 8) begin
            miscompares++;
            $display("FAIL rr_spacing got %p want spacing 8", when);
        end
        order.delete();
        set_req(2, 1, 1); set_req(0, 1, 1);
        for (int i = 0; i < 30; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rr2_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
            if (|(obs_ready & obs_valid)) order.push_back(oh2int(obs_ready & obs_valid));
        end
        vectors++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 2) begin
            miscompares++;
            $display("FAIL rr2_order got %p want 0,2", order);
        end
    endtask

    task automatic test_zero_params();
        do_reset();
        set_req(2, 0, 1);
        cycle();
        for (int i = 1; i <= 7; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL hp0_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i <= 3) begin
                vectors++;
                if ({pwm, done} !== ((i == 1) ? 6'b100_000 : (i == 2) ? 6'b000_000 : 6'b000_100)) begin
                    miscompares++;
                    $display("FAIL hp0_wave cyc%0d {pwm,done} got %b", i, {pwm, done});
                end
            end
        end
        set_req(0, 7, 0);
        cycle();
        vectors++;
        if ({obs_ready, pwm, done, active_ch} !== {3'b001, 3'b000, 3'b001, 2'd0}) begin
            miscompares++;
            $display("FAIL n0_load {rdy,pwm,done,act} got %b want 00100000100", {obs_ready, pwm, done, active_ch});
        end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec() || pwm[0] !== 1'b0 || done !== 3'b000) begin
                miscompares++;
                $display("FAIL n0_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_abort();
        int  hs1;
        logic saw_done0;
        hs1 = -1;
        saw_done0 = 1'b0;
        do_reset();
        set_req(0, 5, 10); set_req(1, 2, 1);
        cycle();
        vectors++;
        if (obs_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL abort_accept ready got %b want 001", obs_ready);
        end
        for (int i = 1; i <= 40; i++) begin
            if (i == 24) abort = 1'b1;
            cycle();
            abort = 1'b0;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i == 23 || i == 24) begin
                vectors++;
                if (pwm !== ((i == 23) ? 3'b001 : 3'b000)) begin
                    miscompares++;
                    $display("FAIL abort_pwm cyc%0d got %b", i, pwm);
                end
            end
            if (done[0]) saw_done0 = 1'b1;
            if (hs1 < 0 && (obs_ready & obs_valid) == 3'b010) hs1 = i;
        end
        vectors++;
        if (saw_done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done got done[0] pulse want none");
        end
        vectors++;
        if (hs1 != 24 + GAP + 1) begin
            miscompares++;
            $display("FAIL abort_next_accept got cycle %0d want %0d", hs1, 24 + GAP + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        set_req(0, 4, 3);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midrst_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (pwm !== 3'b001) begin
            miscompares++;
            $display("FAIL midrst_pre pwm got %b want 001", pwm);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({pwm, busy, active_ch} !== {3'b000, 1'b0, 2'd3}) begin
            miscompares++;
            $display("FAIL midrst_async {pwm,busy,act} got %b want 000011", {pwm, busy, active_ch});
        end
        @(posedge sys_clk);
        #1;
        vectors++;
        if ({req_ready, pwm, done, busy, active_ch} !== {3'b000, 3'b000, 3'b000, 1'b0, 2'd3}) begin
            miscompares++;
            $display("FAIL midrst_hold got %b want 000000000011", {req_ready, pwm, done, busy, active_ch});
        end
        sys_rst_n = 1'b1;
        model_reset();
        set_req(1, 1, 1); set_req(0, 1, 1);
        cycle();
        vectors++;
        if (obs_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL midrst_first_arb ready got %b want 001", obs_ready);
        end
        for (int i = 1; i <= 20; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midrst_post%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++)
                if (!req_valid[c] && $urandom_range(0, 9) == 0)
                    set_req(c, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            abort = ($urandom_range(0, 39) == 0);
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cyc%0d {rdy,pwm,done,busy,act} got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_params();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog bench did not complete within time limit");
        $fatal(1);
    end

endmodule
